loadable_counter: RTL and testbench
===================================

Name: loadable_counter

Overview:
- Synchronous, parameterised-width up-counter with parallel load and count-enable.
- General-purpose building block for sequencing, timers and address generation.
- Single clock domain (CLK) with a synchronous, active-high reset (RESET).
- The count value is presented on COUNT directly from the state register.

Parameters:
- WIDTH, default 4: bit width of DATA and COUNT. Legal range is >= 1.

Ports:
- CLK  input  1  clock. All state changes occur on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- LOAD  input  1  parallel-load strobe, active-high.
- DATA  input  WIDTH  value loaded into the counter when LOAD is asserted.
- INC  input  1  count-enable, active-high.
- COUNT  output  WIDTH  current counter value, driven directly from a register.

Behaviour:
- The design uses one clock and one reset. Reset is synchronous and active-high; it acts only on the rising edge of CLK.
- All outputs are registered. COUNT has no combinational path from any input.
- On each rising CLK edge, the first matching rule in this priority order applies:
  1. RESET=1: COUNT <= 0. LOAD, INC and DATA are ignored.
  2. LOAD=1: COUNT <= DATA. INC is ignored in that cycle.
  3. INC=1: COUNT <= (COUNT + 1) mod 2^WIDTH.
  4. Otherwise COUNT holds its value.
- Latency:
  - Every action takes effect on the first rising edge at which the control input is sampled high.
  - The new value is visible on COUNT immediately after that edge.
- Wrap-around: at INC with COUNT = 2^WIDTH-1, the next value is 0. No carry or overflow flag is produced, and there is no saturation.
- Load value:
  - DATA is used as-is, WIDTH bits wide.
  - Callers driving wider constants get truncation to the low WIDTH bits at the port. For example, a decimal 1100 at WIDTH=4 loads 4'b1100 = 12.
- Held LOAD: COUNT reloads DATA on every edge and does not advance.
- Power-up: COUNT is undefined until the first edge with RESET=1. No initial value is relied upon.
- Reset mid-operation:
  - RESET asserted during counting or loading clears COUNT to 0 at the next edge.
  - After RESET deasserts, counting resumes from 0 on the next edge at which INC=1.
- No internal state exists beyond the WIDTH-bit count register.

Test Plan:
- Reset:
  - Stimulus: WIDTH=4, RESET=1 and INC=1 for one rising edge.
  - Response: COUNT=0000 after that edge, despite INC=1.
- Count:
  - Stimulus: release RESET with INC=1, LOAD=0; run 3 rising edges.
  - Response: COUNT steps 0001, 0010, 0011.
- Load priority over INC:
  - Stimulus: LOAD=1, INC=1, DATA=1100 (decimal constant) for one edge.
  - Response: COUNT=1100 (12), not 0100.
- Wrap-around:
  - Stimulus: from COUNT=1100, LOAD=0, INC=1 for 5 edges.
  - Response: COUNT = 1101, 1110, 1111, 0000, 0001.
- Hold:
  - Stimulus: INC=0, LOAD=0 for 5 edges.
  - Response: COUNT stays 0001.
- Reset mid-count and parameterisation:
  - Stimulus: RESET=1 while INC=1 and COUNT nonzero.
  - Response: COUNT=0 at the next edge.
  - Stimulus: repeat the count and wrap checks with WIDTH=8.
  - Response: 8'hFF + 1 = 8'h00.

Source files
------------

// File: rtl/loadable_counter.sv
// Parameterised up-counter with synchronous reset, parallel load and count-enable.
// Priority on each rising edge is RESET, then LOAD, then INC, otherwise hold.
module loadable_counter #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DATA,
    input  logic             INC,
    output logic [WIDTH-1:0] COUNT
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        // NOTE: assigning the hold value first means every path writes count_d, so no latch is inferred.
        count_d = count_q;
        if (LOAD) begin
            count_d = DATA;
        end else if (INC) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Reset is checked only inside the clocked block, which keeps it synchronous and gives it top priority.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignment so every flop samples the pre-edge value of count_d.
        if (RESET) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign COUNT = count_q;

endmodule

// File: tb/tb_loadable_counter.sv
// Self-checking bench for loadable_counter at WIDTH=4 and WIDTH=8: directed
// scenarios followed by randomized control traffic compared against a reference model.
module tb_loadable_counter;

    logic       clk = 1'b0;
    logic       r4, l4, i4;
    logic [3:0] d4;
    logic [3:0] c4;
    logic       r8, l8, i8;
    logic [7:0] d8;
    logic [7:0] c8;

    int total = 0;
    int bad   = 0;
    int m4    = 0;
    int m8    = 0;

    always #5 clk = ~clk;

    loadable_counter #(.WIDTH(4)) dut4 (
        .CLK(clk), .RESET(r4), .LOAD(l4), .DATA(d4), .INC(i4), .COUNT(c4)
    );

    loadable_counter #(.WIDTH(8)) dut8 (
        .CLK(clk), .RESET(r8), .LOAD(l8), .DATA(d8), .INC(i8), .COUNT(c8)
    );

    // Next counter value from the priority rules, using modular integer arithmetic.
    function automatic int ref_next(int cur, bit rst, bit ld, int data, bit inc, int w);
        int modulus = 1 << w;
        if (rst)      return 0;
        else if (ld)  return data % modulus;
        else if (inc) return (cur + 1) % modulus;
        else          return cur;
    endfunction

    // One rising edge; models advance from the inputs that the edge samples.
    task automatic step();
        m4 = ref_next(m4, r4, l4, int'(d4), i4, 4);
        m8 = ref_next(m8, r8, l8, int'(d8), i8, 8);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        r4 = 1'b1; l4 = 1'b0; i4 = 1'b1; d4 = 4'd0;
        r8 = 1'b1; l8 = 1'b0; i8 = 1'b1; d8 = 8'd0;
        step();
        total++;
        if (c4 !== 4'd0) begin
            bad++;
            $display("FAIL reset_w4: got %b expected 0000", c4);
        end
        total++;
        if (c8 !== 8'd0) begin
            bad++;
            $display("FAIL reset_w8: got %h expected 00", c8);
        end
    endtask

    task automatic test_count();
        logic [3:0] exp_seq [3] = '{4'd1, 4'd2, 4'd3};
        r4 = 1'b0; l4 = 1'b0; i4 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (c4 !== exp_seq[k]) begin
                bad++;
                $display("FAIL count_w4[%0d]: got %b expected %b", k, c4, exp_seq[k]);
            end
        end
    endtask

    task automatic test_load_priority();
        // Decimal 1100 truncated to 4 bits is 4'b1100.
        l4 = 1'b1; i4 = 1'b1; d4 = 4'(1100);
        step();
        total++;
        if (c4 !== 4'd12) begin
            bad++;
            $display("FAIL load_priority_w4: got %b expected 1100", c4);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_seq [5] = '{4'd13, 4'd14, 4'd15, 4'd0, 4'd1};
        l4 = 1'b0; i4 = 1'b1; d4 = 4'd0;
        for (int k = 0; k < 5; k++) begin
            step();
            total++;
            if (c4 !== exp_seq[k]) begin
                bad++;
                $display("FAIL wrap_w4[%0d]: got %b expected %b", k, c4, exp_seq[k]);
            end
        end
    endtask

    task automatic test_hold();
        l4 = 1'b0; i4 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            total++;
            if (c4 !== 4'd1) begin
                bad++;
                $display("FAIL hold_w4[%0d]: got %b expected 0001", k, c4);
            end
        end
    endtask

    task automatic test_held_load();
        l4 = 1'b1; i4 = 1'b1; d4 = 4'd6;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (c4 !== 4'd6) begin
                bad++;
                $display("FAIL held_load_w4[%0d]: got %b expected 0110", k, c4);
            end
        end
        l4 = 1'b0;
    endtask

    task automatic test_reset_mid();
        i4 = 1'b1; l4 = 1'b0;
        step();
        total++;
        if (c4 !== 4'd7) begin
            bad++;
            $display("FAIL pre_reset_w4: got %b expected 0111", c4);
        end
        r4 = 1'b1; l4 = 1'b1; d4 = 4'd9;
        step();
        total++;
        if (c4 !== 4'd0) begin
            bad++;
            $display("FAIL reset_mid_w4: got %b expected 0000", c4);
        end
        r4 = 1'b0; l4 = 1'b0;
        step();
        total++;
        if (c4 !== 4'd1) begin
            bad++;
            $display("FAIL resume_w4: got %b expected 0001", c4);
        end
    endtask

    task automatic test_width8();
        logic [7:0] cnt_seq  [3] = '{8'h01, 8'h02, 8'h03};
        logic [7:0] wrap_seq [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        r8 = 1'b0; l8 = 1'b0; i8 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (c8 !== cnt_seq[k]) begin
                bad++;
                $display("FAIL count_w8[%0d]: got %h expected %h", k, c8, cnt_seq[k]);
            end
        end
        l8 = 1'b1; d8 = 8'hFD;
        step();
        total++;
        if (c8 !== 8'hFD) begin
            bad++;
            $display("FAIL load_w8: got %h expected fd", c8);
        end
        l8 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            total++;
            if (c8 !== wrap_seq[k]) begin
                bad++;
                $display("FAIL wrap_w8[%0d]: got %h expected %h", k, c8, wrap_seq[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            r4 = ($urandom_range(0, 19) == 0);
            l4 = ($urandom_range(0, 5) == 0);
            i4 = ($urandom_range(0, 3) != 0);
            d4 = 4'($urandom);
            r8 = ($urandom_range(0, 19) == 0);
            l8 = ($urandom_range(0, 9) == 0);
            i8 = ($urandom_range(0, 4) != 0);
            d8 = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            step();
            total++;
            if (c4 !== 4'(m4)) begin
                bad++;
                $display("FAIL random_w4[%0d]: got %0d expected %0d", k, c4, m4);
            end
            total++;
            if (c8 !== 8'(m8)) begin
                bad++;
                $display("FAIL random_w8[%0d]: got %0d expected %0d", k, c8, m8);
            end
        end
    endtask

    initial begin
        r4 = 1'b0; l4 = 1'b0; i4 = 1'b0; d4 = 4'd0;
        r8 = 1'b0; l8 = 1'b0; i8 = 1'b0; d8 = 8'd0;
        #1;
        test_reset();
        test_count();
        test_load_priority();
        test_wrap();
        test_hold();
        test_held_load();
        test_reset_mid();
        test_width8();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
